// File: rtl/clz_norm_seq.sv
// Multi-cycle leading-zero count and left-normalize for wide words.
// Scans one CHUNK_W slice per cycle MSB-first, then shifts once and holds the result.
module clz_norm_seq #(
  parameter int DATA_W  = 279,
  parameter int CHUNK_W = 32,
  parameter int OUT_W   = 9
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [OUT_W-1:0]  lzc_o,
  output logic              zero_o,
  output logic [1:0]        state_o
);

  localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // valid_o, once raised, stays high until ready_i is seen (or clear/reset).

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data_q;
  logic [OUT_W-1:0]  lzc_q;
  logic              zero_q;

  logic [PAD_W-1:0]   padded;
  logic [CHUNK_W-1:0] chunk;
  logic [OUT_W-1:0]   lzc_next;
  logic               last_chunk;

  function automatic logic [OUT_W-1:0] clz_chunk(input logic [CHUNK_W-1:0] c);
    clz_chunk = OUT_W'(CHUNK_W);
    // Upward scan: the last hit is the highest set bit.
    for (int i = 0; i < CHUNK_W; i++) begin
      if (c[i]) clz_chunk = OUT_W'(CHUNK_W - 1 - i);
    end
  endfunction

  always_comb begin
    padded = PAD_W'(data_q) << (PAD_W - DATA_W);
    chunk  = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) chunk = padded[PAD_W-1-i*CHUNK_W -: CHUNK_W];
    end
    lzc_next   = OUT_W'(idx) * OUT_W'(CHUNK_W) + clz_chunk(chunk);
    last_chunk = (idx == IDX_W'(NCHUNK - 1));
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == OUT);
  assign state_o = state;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
      lzc_q  <= '0;
      zero_q <= 1'b0;
      data_o <= '0;
      lzc_o  <= '0;
      zero_o <= 1'b0;
    end else if (clear_i) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            data_q <= data_i;
            idx    <= '0;
            zero_q <= 1'b0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (chunk != '0) begin
            lzc_q <= lzc_next;
            state <= SHIFT;
          end else if (last_chunk) begin
            lzc_q  <= OUT_W'(DATA_W);
            zero_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SHIFT: begin
          // Result registers only change here, so they hold across the idle gap.
          data_o <= zero_q ? '0 : (data_q << lzc_q);
          lzc_o  <= lzc_q;
          zero_o <= zero_q;
          state  <= OUT;
        end
        OUT: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clz_norm_seq.md
# clz_norm_seq

Multi-cycle normalization sequencer for wide accumulator words. It accepts a DATA_W-bit value over a valid/ready handshake and scans it MSB-first one CHUNK_W-bit chunk per cycle, stopping at the first non-zero chunk. It then produces the leading-zero count and the left-normalized value, and holds the result on a valid/ready output. It sits between the wide accumulator and the float/fixed-point output formatter. It replaces a single DATA_W-wide combinational leading-zero counter with a narrow per-chunk one to shorten the critical path.

## Interface
- DATA_W, 279, width of the input and normalized output word.
- CHUNK_W, 32, bits examined per SCAN cycle; 1 ≤ CHUNK_W ≤ DATA_W.
- OUT_W, 9, width of the leading-zero count; must satisfy OUT_W ≥ $clog2(DATA_W+1).
- clk_i  input  1  clock; all state changes on the rising edge.
- arst_i  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous abort; returns to IDLE and drops any in-flight operation.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept a word; high only in IDLE.
- data_i  input  DATA_W  word to normalize.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- data_o  output  DATA_W  data_i shifted left by lzc_o and truncated to DATA_W bits; 0 when zero_o=1.
- lzc_o  output  OUT_W  leading-zero count of data_i, range 0..DATA_W.
- zero_o  output  1  data_i was all zeros (lzc_o = DATA_W).

## Operation
- NCHUNK = ceil(DATA_W/CHUNK_W). The captured word is zero-padded at the LSB end to NCHUNK*CHUNK_W bits.
  - Chunk 0 is the most-significant chunk.
  - Padding never affects the count of a non-zero word.
- Chunk index register: $clog2(NCHUNK) bits, minimum 1.
- lzc is computed as idx*CHUNK_W + clz(chunk) in OUT_W bits.
- States:
  - IDLE: ready_o=1. When valid_i=1, capture data_i, set idx=0, clear zero flag, go to SCAN.
  - SCAN: examine chunk idx.
    - Chunk non-zero: latch lzc, go to SHIFT.
    - Chunk zero and idx=NCHUNK-1: latch lzc=DATA_W and zero=1, go to SHIFT.
    - Otherwise: idx=idx+1 and stay in SCAN.
  - SHIFT: data register ← data register << lzc, truncated to DATA_W bits. When zero=1, force data_o to 0. Go to OUT.
  - OUT: valid_o=1. When ready_i=1, go to IDLE.
- clear_i applies in any state. It forces IDLE, valid_o=0, and idx=0. It has priority over valid_i and ready_i in the same cycle.
- Only one word is in flight at a time. ready_o=0 from SCAN through OUT, and valid_i is ignored there.

## Timing
- Reset (arst_i=1): state=IDLE, idx=0, valid_o=0, data_o=0, lzc_o=0, zero_o=0.
  - ready_o follows state, so it reads 1 while in IDLE, including during reset.
  - Inputs are ignored while arst_i=1.
  - Reset mid-operation discards the word; no partial result ever appears.
- Input handshake in cycle T; k = index of the first non-zero chunk, or NCHUNK-1 if none:
  - SCAN occupies T+1 .. T+1+k.
  - SHIFT occupies T+2+k.
  - valid_o rises in cycle T+3+k.
  - Defaults: latency ranges from 3 cycles (MSB chunk non-zero) to 11 cycles (zero word, or non-zero data only in chunk 8).
- data_o, lzc_o and zero_o are registered and stable for the whole time valid_o=1. They hold their values after the output handshake until the next result.
- Output handshake in cycle U: ready_o=1 in U+1. Minimum spacing between accepted inputs is k+4 cycles.
- ready_i is ignored outside OUT. valid_o never drops without an output handshake, except on clear_i or arst_i.

## Test plan
- data_i = 1<<278, handshake at T -> valid_o at T+3, lzc_o=0, zero_o=0, data_o=1<<278.
- data_i = 1<<246 (first bit of chunk 1) -> valid_o at T+4, lzc_o=32, data_o=1<<278. Also data_i = 1<<247 -> valid_o at T+3, lzc_o=31.
- data_i = 1 -> valid_o at T+11, lzc_o=278, zero_o=0, data_o=1<<278.
- data_i = 0 -> valid_o at T+11, lzc_o=279, zero_o=1, data_o=0.
- Back-pressure:
  - Stimulus: result valid, ready_i held low for 5 cycles while valid_i=1 with a new word.
  - Required: outputs stable, ready_o=0, new word not taken.
  - Then raise ready_i: ready_o=1 next cycle, new word accepted, correct result returned.
- Abort:
  - Stimulus: arst_i pulsed during SCAN; separately, clear_i asserted during SHIFT.
  - Required: valid_o stays 0 and ready_o=1 the next cycle.
  - A following word 0x3 produces lzc_o=277 with correct latency.
